// File: rtl/ahb_bus_arbiter_if.sv
// Arbiter-facing signals of a shared AHB segment: requests and muxed control in, grant and ownership out.
interface ahb_bus_arbiter_if #(
    parameter int unsigned NMASTER = 4
);
    logic [NMASTER-1:0] HBUSREQ;
    logic [NMASTER-1:0] HLOCK;
    logic [1:0]         HTRANS;
    logic [2:0]         HBURST;
    logic               HREADY;
    logic               HRESP;
    logic [NMASTER-1:0] HGRANT;
    logic [3:0]         HMASTER;
    logic [3:0]         HMASTERD;
    logic               HMASTLOCK;

    // Bus-master / bus-control side
    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        input  HGRANT, HMASTER, HMASTERD, HMASTLOCK
    );

    // Arbiter side
    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
        output HGRANT, HMASTER, HMASTERD, HMASTLOCK
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter for up to four masters.
// Holds the grant through fixed bursts, INCR runs and locked sequences, and parks on a default master.
module ahb_bus_arbiter #(
    parameter int unsigned NMASTER   = 4,
    parameter int unsigned DEFMASTER = 0,
    parameter int unsigned MAXBEAT   = 16
) (
    input logic              HCLK,
    input logic              HRESET,
    ahb_bus_arbiter_if.slave bus
);
    localparam int unsigned IW   = 2;
    localparam int unsigned CMAX = (MAXBEAT > 16) ? MAXBEAT : 16;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_INCR   = 3'b001;

    typedef enum logic [1:0] {PARK, OWN, BURST, LOCK} state_t;

    state_t             state, state_nxt;
    logic [NMASTER-1:0] grant;
    logic [IW-1:0]      gidx, mst, mstd, ptr, win, cand;
    logic [CW-1:0]      cnt, cnt_nxt, cnt_inc, bend, bend_nxt;
    logic               incr, incr_nxt, err, mlock;
    logic               any_req, arb, owner_act, owner_req, owner_lock, fixed;

    // Round-robin winner: nearest requester after the pointer, the pointer itself last
    always_comb begin
        win  = IW'(DEFMASTER);
        cand = '0;
        for (int k = int'(NMASTER); k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % int'(NMASTER));
            if (bus.HBUSREQ[cand]) win = cand;
        end
    end

    // Arbitration-point detection and hold-state bookkeeping for an HREADY=1 edge
    always_comb begin
        any_req    = |bus.HBUSREQ;
        owner_act  = (mst == gidx);
        owner_req  = bus.HBUSREQ[gidx];
        owner_lock = bus.HLOCK[gidx];
        fixed      = (bus.HBURST[2:1] != 2'b00);
        cnt_inc    = cnt + CW'(1);
        arb        = 1'b0;
        state_nxt  = state;
        cnt_nxt    = cnt;
        bend_nxt   = bend;
        incr_nxt   = incr;
        case (state)
            PARK: arb = 1'b1;
            LOCK: arb = !owner_lock;
            BURST: begin
                if (bus.HTRANS == TR_SEQ) begin
                    cnt_nxt = cnt_inc;
                    arb     = (cnt_inc == bend);
                end else if (bus.HTRANS == TR_IDLE) begin
                    arb = 1'b1;
                end
            end
            default: begin
                if (owner_act && bus.HTRANS == TR_NONSEQ && fixed) begin
                    state_nxt = BURST;
                    cnt_nxt   = CW'(1);
                    incr_nxt  = 1'b0;
                    bend_nxt  = bus.HBURST[2] ? (bus.HBURST[1] ? CW'(15) : CW'(7)) : CW'(3);
                end else if (owner_act && owner_req && bus.HTRANS == TR_NONSEQ
                             && bus.HBURST == BU_INCR) begin
                    cnt_nxt  = CW'(1);
                    incr_nxt = 1'b1;
                end else if (owner_act && owner_req && incr && bus.HTRANS[0]) begin
                    // SEQ or BUSY of an undefined-length INCR; only SEQ counts
                    if (bus.HTRANS == TR_SEQ) cnt_nxt = cnt_inc;
                    arb = (bus.HTRANS == TR_SEQ) && (cnt_inc >= CW'(MAXBEAT));
                end else begin
                    arb = 1'b1;
                end
            end
        endcase
        if ((state == OWN || state == BURST) && owner_lock) begin
            arb       = 1'b0;
            state_nxt = LOCK;
        end
        if (err && state != LOCK) arb = 1'b1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= PARK;
            grant <= NMASTER'(1) << DEFMASTER;
            gidx  <= IW'(DEFMASTER);
            mst   <= IW'(DEFMASTER);
            mstd  <= IW'(DEFMASTER);
            ptr   <= IW'(DEFMASTER);
            cnt   <= '0;
            bend  <= '0;
            incr  <= 1'b0;
            err   <= 1'b0;
            mlock <= 1'b0;
        end else if (!bus.HREADY) begin
            // Wait states freeze everything except the first ERROR cycle, which aborts the burst
            if (bus.HRESP) begin
                cnt  <= '0;
                incr <= 1'b0;
                err  <= 1'b1;
                if (state == BURST) state <= OWN;
            end
        end else begin
            mst   <= gidx;
            mstd  <= mst;
            mlock <= owner_lock;
            err   <= 1'b0;
            if (arb) begin
                cnt  <= '0;
                incr <= 1'b0;
                if (any_req) begin
                    grant <= NMASTER'(1) << win;
                    gidx  <= win;
                    ptr   <= win;
                    state <= bus.HLOCK[win] ? LOCK : OWN;
                end else begin
                    grant <= NMASTER'(1) << DEFMASTER;
                    gidx  <= IW'(DEFMASTER);
                    state <= PARK;
                end
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                bend  <= bend_nxt;
                incr  <= incr_nxt;
            end
        end
    end

    assign bus.HGRANT    = grant;
    assign bus.HMASTER   = 4'(mst);
    assign bus.HMASTERD  = 4'(mstd);
    assign bus.HMASTLOCK = mlock;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed, table-driven bench for ahb_bus_arbiter (4 masters, parking on M0, MAXBEAT 16).
module tb_ahb_bus_arbiter;
    localparam int unsigned NM = 4;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] NSQ  = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;

    logic HCLK = 1'b0;
    logic HRESET;

    ahb_bus_arbiter_if #(.NMASTER(NM)) bus ();

    ahb_bus_arbiter #(.NMASTER(NM), .DEFMASTER(0), .MAXBEAT(16)) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       ready;
        logic       resp;
        logic [3:0] grant;
        logic [3:0] mst;
        logic [3:0] mstd;
        logic       mlock;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic [3:0] req, input logic [3:0] lock,
                                input logic [1:0] trans, input logic [2:0] burst,
                                input logic ready, input logic resp,
                                input logic [3:0] grant, input logic [3:0] mst,
                                input logic [3:0] mstd, input logic mlock);
        vec_t v;
        v.req = req;     v.lock = lock;   v.trans = trans; v.burst = burst;
        v.ready = ready; v.resp = resp;   v.grant = grant; v.mst = mst;
        v.mstd = mstd;   v.mlock = mlock;
        vecs.push_back(v);
    endfunction

    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic drive_idle();
        bus.HBUSREQ = '0;
        bus.HLOCK   = '0;
        bus.HTRANS  = IDLE;
        bus.HBURST  = 3'b000;
        bus.HREADY  = 1'b1;
        bus.HRESP   = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] g, input logic [3:0] m,
                                 input logic [3:0] md, input logic ml);
        check({tag, ".grant"}, 8'(bus.HGRANT), 8'(g));
        check({tag, ".hmaster"}, 8'(bus.HMASTER), 8'(m));
        check({tag, ".hmasterd"}, 8'(bus.HMASTERD), 8'(md));
        check({tag, ".mastlock"}, 8'(bus.HMASTLOCK), 8'(ml));
    endtask

    // Apply queued vectors one clock each, compare one time unit after the edge
    task automatic run_vecs(input string seg);
        foreach (vecs[i]) begin
            bus.HBUSREQ = vecs[i].req;
            bus.HLOCK   = vecs[i].lock;
            bus.HTRANS  = vecs[i].trans;
            bus.HBURST  = vecs[i].burst;
            bus.HREADY  = vecs[i].ready;
            bus.HRESP   = vecs[i].resp;
            @(posedge HCLK);
            #1;
            check_outputs($sformatf("%s[%0d]", seg, i), vecs[i].grant, vecs[i].mst,
                          vecs[i].mstd, vecs[i].mlock);
        end
        vecs.delete();
    endtask

    initial begin
        HRESET = 1'b1;
        drive_idle();
        #12;
        do_reset();
        check_outputs("reset", 4'b0001, 4'd0, 4'd0, 1'b0);

        // Parked on M0 with no requests
        for (int i = 0; i < 10; i++) add(4'b0000, 4'b0000, IDLE, 3'b000, 1, 0, 4'b0001, 0, 0, 0);
        run_vecs("park");

        // M1..M3 continuous SINGLE requests rotate every cycle
        do_reset();
        add(4'b1110, 4'b0000, IDLE, 3'b000, 1, 0, 4'b0010, 0, 0, 0);
        add(4'b1110, 4'b0000, NSQ,  3'b000, 1, 0, 4'b0100, 1, 0, 0);
        add(4'b1110, 4'b0000, NSQ,  3'b000, 1, 0, 4'b1000, 2, 1, 0);
        add(4'b1110, 4'b0000, NSQ,  3'b000, 1, 0, 4'b0010, 3, 2, 0);
        add(4'b1110, 4'b0000, NSQ,  3'b000, 1, 0, 4'b0100, 1, 3, 0);
        run_vecs("rr");

        // M2 INCR8 with M1 waiting: handover on the beat-7 edge
        do_reset();
        add(4'b0100, 4'b0000, IDLE, 3'b000, 1, 0, 4'b0100, 0, 0, 0);
        add(4'b0100, 4'b0000, IDLE, 3'b000, 1, 0, 4'b0100, 2, 0, 0);
        add(4'b0110, 4'b0000, NSQ,  3'b101, 1, 0, 4'b0100, 2, 2, 0);
        for (int i = 0; i < 5; i++) add(4'b0110, 4'b0000, SEQ, 3'b101, 1, 0, 4'b0100, 2, 2, 0);
        add(4'b0110, 4'b0000, SEQ,  3'b101, 1, 0, 4'b0010, 2, 2, 0);
        add(4'b0010, 4'b0000, SEQ,  3'b101, 1, 0, 4'b0010, 1, 2, 0);
        add(4'b0010, 4'b0000, NSQ,  3'b000, 1, 0, 4'b0010, 1, 1, 0);
        run_vecs("incr8");

        // M3 INCR4 with BUSY beats and three wait states on beat 2, M0 waiting
        do_reset();
        add(4'b1000, 4'b0000, IDLE, 3'b000, 1, 0, 4'b1000, 0, 0, 0);
        add(4'b1000, 4'b0000, IDLE, 3'b000, 1, 0, 4'b1000, 3, 0, 0);
        add(4'b1001, 4'b0000, NSQ,  3'b011, 1, 0, 4'b1000, 3, 3, 0);
        add(4'b1001, 4'b0000, BUSY, 3'b011, 1, 0, 4'b1000, 3, 3, 0);
        for (int i = 0; i < 3; i++) add(4'b1001, 4'b0000, SEQ, 3'b011, 0, 0, 4'b1000, 3, 3, 0);
        add(4'b1001, 4'b0000, SEQ,  3'b011, 1, 0, 4'b1000, 3, 3, 0);
        add(4'b1001, 4'b0000, BUSY, 3'b011, 1, 0, 4'b1000, 3, 3, 0);
        add(4'b1001, 4'b0000, SEQ,  3'b011, 1, 0, 4'b0001, 3, 3, 0);
        add(4'b0001, 4'b0000, SEQ,  3'b011, 1, 0, 4'b0001, 0, 3, 0);
        run_vecs("incr4");

        // M1 locked across two INCR4 bursts while M0 and M2 request
        do_reset();
        add(4'b0010, 4'b0010, IDLE, 3'b000, 1, 0, 4'b0010, 0, 0, 0);
        add(4'b0111, 4'b0010, IDLE, 3'b000, 1, 0, 4'b0010, 1, 0, 1);
        for (int b = 0; b < 2; b++) begin
            add(4'b0111, 4'b0010, NSQ, 3'b011, 1, 0, 4'b0010, 1, 1, 1);
            for (int i = 0; i < 3; i++) add(4'b0111, 4'b0010, SEQ, 3'b011, 1, 0, 4'b0010, 1, 1, 1);
        end
        add(4'b0111, 4'b0000, IDLE, 3'b000, 1, 0, 4'b0100, 1, 1, 0);
        run_vecs("lock");

        // ERROR on beat 3 of M0 INCR16 releases the bus to waiting M1
        do_reset();
        add(4'b0001, 4'b0000, IDLE, 3'b000, 1, 0, 4'b0001, 0, 0, 0);
        add(4'b0011, 4'b0000, NSQ,  3'b111, 1, 0, 4'b0001, 0, 0, 0);
        add(4'b0011, 4'b0000, SEQ,  3'b111, 1, 0, 4'b0001, 0, 0, 0);
        add(4'b0011, 4'b0000, SEQ,  3'b111, 1, 0, 4'b0001, 0, 0, 0);
        add(4'b0011, 4'b0000, SEQ,  3'b111, 0, 1, 4'b0001, 0, 0, 0);
        add(4'b0011, 4'b0000, IDLE, 3'b111, 1, 1, 4'b0010, 0, 0, 0);
        run_vecs("error");

        // Asynchronous reset in the middle of an M2 INCR16
        do_reset();
        add(4'b0100, 4'b0000, IDLE, 3'b000, 1, 0, 4'b0100, 0, 0, 0);
        add(4'b0100, 4'b0000, IDLE, 3'b000, 1, 0, 4'b0100, 2, 0, 0);
        add(4'b0110, 4'b0000, NSQ,  3'b111, 1, 0, 4'b0100, 2, 2, 0);
        add(4'b0110, 4'b0000, SEQ,  3'b111, 1, 0, 4'b0100, 2, 2, 0);
        run_vecs("preirst");
        #2;
        HRESET = 1'b1;
        #1;
        check_outputs("async_rst", 4'b0001, 4'd0, 4'd0, 1'b0);
        #1;
        HRESET = 1'b0;
        add(4'b0110, 4'b0000, SEQ,  3'b111, 1, 0, 4'b0010, 0, 0, 0);
        run_vecs("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
